// File: rtl/branch_unit.sv
// Branch/jump resolution unit: evaluates the condition, computes the target
// and link, and holds the result behind a valid/ready output register.
// Ports:
//   req_*      request (valid/ready; kind, funct3, rs1, rs2, pc, imm)
//   flush      kills the held result and blocks acceptance
//   rsp_*      held result (taken, target, link, misaligned, illegal)
//   redirect_* one-cycle redirect pulse to fetch
//   cnt_*      saturating branch/taken event counters, cnt_clear zeroes them
module branch_unit #(
  parameter int Width        = 32,
  parameter bit CompressedEn = 1'b0,
  parameter int CntWidth     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_kind,
  input  logic [2:0]          req_op,
  input  logic [Width-1:0]    req_a,
  input  logic [Width-1:0]    req_b,
  input  logic [Width-1:0]    req_pc,
  input  logic [Width-1:0]    req_imm,
  input  logic                flush,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_taken,
  output logic [Width-1:0]    rsp_target,
  output logic [Width-1:0]    rsp_link,
  output logic                rsp_misaligned,
  output logic                rsp_illegal,
  output logic                redirect_valid,
  output logic [Width-1:0]    redirect_pc,
  output logic [CntWidth-1:0] cnt_branch,
  output logic [CntWidth-1:0] cnt_taken,
  input  logic                cnt_clear
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic             taken;
    logic [Width-1:0] target;
    logic [Width-1:0] link;
    logic             mis;
    logic             ill;
  } res_t;

  state_t state, state_nx;
  res_t   res, hold;

  logic             accept;
  logic             is_br, is_jal, is_jalr;
  logic             cond, op_ill;
  logic             fire;
  logic             br_ev, tk_ev;
  logic [Width-1:0] link;
  logic [Width-1:0] pc_imm;
  logic [Width-1:0] a_imm;
  logic [Width-1:0] jalr_t;

  localparam logic [CntWidth-1:0] CntMax = '1;

  // rst gating keeps every output low while reset is held
  assign req_ready = !rst && !flush &&
                     (state == EMPTY || rsp_ready);
  assign accept    = req_valid && req_ready;

  assign is_br   = req_kind == 2'b00;
  assign is_jal  = req_kind == 2'b01;
  assign is_jalr = req_kind == 2'b10;

  assign link   = req_pc + Width'(4);
  assign pc_imm = req_pc + req_imm;
  assign a_imm  = req_a + req_imm;
  assign jalr_t = {a_imm[Width-1:1], 1'b0};

  always_comb begin
    cond   = 1'b0;
    op_ill = 1'b0;
    unique case (req_op)
      3'b000:  cond = req_a == req_b;
      3'b001:  cond = req_a != req_b;
      3'b100:  cond = $signed(req_a) < $signed(req_b);
      3'b101:  cond = $signed(req_a) >= $signed(req_b);
      3'b110:  cond = req_a < req_b;
      3'b111:  cond = req_a >= req_b;
      default: op_ill = 1'b1;
    endcase
  end

  always_comb begin
    res        = '0;
    res.target = link;
    res.link   = link;
    unique case (1'b1)
      is_br: begin
        res.taken  = cond;
        res.ill    = op_ill;
        res.target = cond ? pc_imm : link;
      end
      is_jal: begin
        res.taken  = 1'b1;
        res.target = pc_imm;
      end
      is_jalr: begin
        res.taken  = 1'b1;
        res.target = jalr_t;
      end
      default: res.ill = 1'b1;
    endcase
    // with compressed support every target is already 2-byte aligned
    res.mis = !CompressedEn && res.taken &&
              res.target[1];
  end

  assign fire  = accept && res.taken &&
                 !res.mis && !res.ill;
  assign br_ev = accept && is_br && !op_ill;
  assign tk_ev = br_ev && cond;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush)
      state_nx = EMPTY;
    else if (accept)
      state_nx = FULL;
    else if (state == FULL && rsp_ready)
      state_nx = EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold           <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      if (flush)
        hold <= '0;
      else if (accept)
        hold <= res;
      // only an accept can raise the pulse, so a stall never repeats it
      redirect_valid <= fire;
      redirect_pc    <= fire ? res.target : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_branch <= '0;
      cnt_taken  <= '0;
    end else if (cnt_clear) begin
      cnt_branch <= '0;
      cnt_taken  <= '0;
    end else begin
      if (br_ev && cnt_branch != CntMax)
        cnt_branch <= cnt_branch + CntWidth'(1);
      if (tk_ev && cnt_taken != CntMax)
        cnt_taken <= cnt_taken + CntWidth'(1);
    end
  end

  assign rsp_valid      = state == FULL;
  assign rsp_taken      = hold.taken;
  assign rsp_target     = hold.target;
  assign rsp_link       = hold.link;
  assign rsp_misaligned = hold.mis;
  assign rsp_illegal    = hold.ill;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: default instance plus a
// CompressedEn=1 / CntWidth=4 instance sharing the same stimulus.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_kind;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b, req_pc, req_imm;
  logic        flush, rsp_ready, cnt_clear;

  logic        req_ready, rsp_valid, rsp_taken;
  logic [31:0] rsp_target, rsp_link, redirect_pc;
  logic        rsp_misaligned, rsp_illegal;
  logic        redirect_valid;
  logic [31:0] cnt_branch, cnt_taken;

  logic        c_req_ready, c_rsp_valid, c_rsp_taken;
  logic [31:0] c_rsp_target, c_rsp_link, c_redirect_pc;
  logic        c_rsp_misaligned, c_rsp_illegal;
  logic        c_redirect_valid;
  logic [3:0]  c_cnt_branch, c_cnt_taken;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_unit u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .req_pc(req_pc), .req_imm(req_imm),
    .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_taken(rsp_taken), .rsp_target(rsp_target),
    .rsp_link(rsp_link),
    .rsp_misaligned(rsp_misaligned),
    .rsp_illegal(rsp_illegal),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .cnt_branch(cnt_branch), .cnt_taken(cnt_taken),
    .cnt_clear(cnt_clear)
  );

  branch_unit #(
    .CompressedEn(1'b1),
    .CntWidth(4)
  ) u_dutc (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(c_req_ready),
    .req_kind(req_kind), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .req_pc(req_pc), .req_imm(req_imm),
    .flush(flush),
    .rsp_valid(c_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_taken(c_rsp_taken), .rsp_target(c_rsp_target),
    .rsp_link(c_rsp_link),
    .rsp_misaligned(c_rsp_misaligned),
    .rsp_illegal(c_rsp_illegal),
    .redirect_valid(c_redirect_valid),
    .redirect_pc(c_redirect_pc),
    .cnt_branch(c_cnt_branch), .cnt_taken(c_cnt_taken),
    .cnt_clear(cnt_clear)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] k,
                       input logic [2:0] op,
                       input logic [31:0] a, b, pc, imm);
    req_valid = 1'b1;
    req_kind  = k;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_pc    = pc;
    req_imm   = imm;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_kind = 2'b00; req_op = 3'b000;
    req_a = '0; req_b = '0; req_pc = '0; req_imm = '0;
    flush = 1'b0; rsp_ready = 1'b1; cnt_clear = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_redir", 32'(redirect_valid), 0);
    chk("rst_target", rsp_target, 0);
    chk("rst_cntb", cnt_branch, 0);
    chk("rst_cntt", cnt_taken, 0);
    rst = 1'b0;

    // signed -1 < 1
    drive(2'b00, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20);
    #1 chk("blt_ready", 32'(req_ready), 1);
    step();
    chk("blt_valid", 32'(rsp_valid), 1);
    chk("blt_taken", 32'(rsp_taken), 1);
    chk("blt_target", rsp_target, 32'h120);
    chk("blt_link", rsp_link, 32'h104);
    chk("blt_redir", 32'(redirect_valid), 1);
    chk("blt_rpc", redirect_pc, 32'h120);
    chk("blt_cntb", cnt_branch, 1);
    chk("blt_cntt", cnt_taken, 1);

    // unsigned 0xFFFFFFFF < 1 is false
    drive(2'b00, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20);
    step();
    chk("bltu_valid", 32'(rsp_valid), 1);
    chk("bltu_taken", 32'(rsp_taken), 0);
    chk("bltu_target", rsp_target, 32'h104);
    chk("bltu_redir", 32'(redirect_valid), 0);
    chk("bltu_rpc", redirect_pc, 0);
    chk("bltu_cntb", cnt_branch, 2);
    chk("bltu_cntt", cnt_taken, 1);

    drive(2'b10, 3'b000, 32'h1003, 32'h0, 32'h200, 32'h0);
    step();
    chk("jalr_target", rsp_target, 32'h1002);
    chk("jalr_link", rsp_link, 32'h204);
    chk("jalr_mis", 32'(rsp_misaligned), 1);
    chk("jalr_redir", 32'(redirect_valid), 0);
    chk("jalrc_mis", 32'(c_rsp_misaligned), 0);
    chk("jalrc_redir", 32'(c_redirect_valid), 1);
    chk("jalrc_rpc", c_redirect_pc, 32'h1002);
    chk("jalr_cntb", cnt_branch, 2);

    // stall with a pending JAL behind a taken BEQ
    drive(2'b00, 3'b000, 32'h5, 32'h5, 32'h300, 32'h40);
    step();
    chk("beq_target", rsp_target, 32'h340);
    chk("beq_redir", 32'(redirect_valid), 1);
    drive(2'b01, 3'b000, 32'h0, 32'h0, 32'h400, 32'h8);
    rsp_ready = 1'b0;
    #1 chk("stall_ready", 32'(req_ready), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_target", rsp_target, 32'h340);
      chk("stall_taken", 32'(rsp_taken), 1);
      chk("stall_redir", 32'(redirect_valid), 0);
      chk("stall_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    #1 chk("b2b_ready", 32'(req_ready), 1);
    step();
    chk("jal_valid", 32'(rsp_valid), 1);
    chk("jal_target", rsp_target, 32'h408);
    chk("jal_link", rsp_link, 32'h404);
    chk("jal_redir", 32'(redirect_valid), 1);
    chk("jal_cntb", cnt_branch, 3);
    chk("jal_cntt", cnt_taken, 2);

    drive(2'b00, 3'b000, 32'h9, 32'h9, 32'h480, 32'h8);
    flush = 1'b1;
    #1 chk("flush_ready", 32'(req_ready), 0);
    step();
    flush = 1'b0;
    chk("flush_valid", 32'(rsp_valid), 0);
    chk("flush_redir", 32'(redirect_valid), 0);
    chk("flush_cntb", cnt_branch, 3);
    chk("flush_cntt", cnt_taken, 2);

    drive(2'b00, 3'b011, 32'h5, 32'h5, 32'h500, 32'h8);
    step();
    chk("ill_valid", 32'(rsp_valid), 1);
    chk("ill_ill", 32'(rsp_illegal), 1);
    chk("ill_taken", 32'(rsp_taken), 0);
    chk("ill_target", rsp_target, 32'h504);
    chk("ill_redir", 32'(redirect_valid), 0);
    chk("ill_cntb", cnt_branch, 3);

    drive(2'b11, 3'b000, 32'h0, 32'h0, 32'h600, 32'h40);
    step();
    chk("rsv_ill", 32'(rsp_illegal), 1);
    chk("rsv_taken", 32'(rsp_taken), 0);
    chk("rsv_target", rsp_target, 32'h604);
    chk("rsv_link", rsp_link, 32'h604);

    drive(2'b01, 3'b000, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h20);
    step();
    chk("wrap_target", rsp_target, 32'h10);
    chk("wrap_link", rsp_link, 32'hFFFF_FFF4);
    chk("wrap_rpc", redirect_pc, 32'h10);
    chk("wrap_ill", 32'(rsp_illegal), 0);

    // signed -1 >= 1 is false
    drive(2'b00, 3'b101, 32'hFFFF_FFFF, 32'h1, 32'h700, 32'h10);
    step();
    chk("bge_taken", 32'(rsp_taken), 0);
    chk("bge_target", rsp_target, 32'h704);
    chk("bge_cntb", cnt_branch, 4);
    chk("bge_cntt", cnt_taken, 2);

    drive(2'b00, 3'b001, 32'h3, 32'h4, 32'h800, 32'hFFFF_FFF0);
    step();
    chk("bne_taken", 32'(rsp_taken), 1);
    chk("bne_target", rsp_target, 32'h7F0);
    chk("bne_cntb", cnt_branch, 5);
    chk("bne_cntt", cnt_taken, 3);

    drive(2'b00, 3'b111, 32'h7, 32'h7, 32'h900, 32'h4);
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    chk("clr_taken", 32'(rsp_taken), 1);
    chk("clr_target", rsp_target, 32'h904);
    chk("clr_cntb", cnt_branch, 0);
    chk("clr_cntt", cnt_taken, 0);
    chk("clrc_cntb", 32'(c_cnt_branch), 0);

    for (int i = 0; i < 17; i++) begin
      drive(2'b00, 3'b000, 32'h1, 32'h1, 32'hA00, 32'h8);
      step();
    end
    chk("sat_cntb", 32'(c_cnt_branch), 32'hF);
    chk("sat_cntt", 32'(c_cnt_taken), 32'hF);
    chk("nosat_cntb", cnt_branch, 17);
    chk("nosat_cntt", cnt_taken, 17);

    drive(2'b01, 3'b000, 32'h0, 32'h0, 32'hB00, 32'h10);
    step();
    chk("pre_valid", 32'(rsp_valid), 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(rsp_valid), 0);
    chk("arst_redir", 32'(redirect_valid), 0);
    chk("arst_taken", 32'(rsp_taken), 0);
    chk("arst_target", rsp_target, 0);
    chk("arst_cntb", cnt_branch, 0);
    chk("arst_ready", 32'(req_ready), 0);
    req_valid = 1'b0;
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Single-stage, handshaked branch/jump resolution unit in the core execute path.
- Accepts one control-transfer request per cycle and evaluates the condition with an internal comparator: BEQ/BNE/BLT/BGE/BLTU/BGEU semantics selected by funct3.
- Computes target and link addresses and registers the result behind a valid/ready output.
- Emits a one-cycle redirect pulse to fetch and keeps saturating branch/taken event counters for the debug/perf block.

Parameters:
Width, 32, datapath and address width
CompressedEn, 0, 1: targets need 2-byte alignment; 0: targets need 4-byte alignment
CntWidth, 32, width of each event counter

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid && req_ready
req_kind  input  2  00 branch, 01 JAL, 10 JALR, 11 reserved
req_op  input  3  branch funct3 (branch kind only)
req_a  input  Width  rs1 value
req_b  input  Width  rs2 value
req_pc  input  Width  instruction PC
req_imm  input  Width  sign-extended immediate
flush  input  1  kill held result, block acceptance
rsp_valid  output  1  result held
rsp_ready  input  1  consumer takes result
rsp_taken  output  1  control transfer taken
rsp_target  output  Width  next PC
rsp_link  output  Width  pc+4 (rd writeback value)
rsp_misaligned  output  1  taken target misaligned
rsp_illegal  output  1  reserved kind or funct3 010/011
redirect_valid  output  1  one-cycle redirect pulse
redirect_pc  output  Width  redirect address
cnt_branch  output  CntWidth  accepted branch-kind requests
cnt_taken  output  CntWidth  accepted taken branch-kind requests
cnt_clear  input  1  synchronous clear of both counters

Behaviour:
- Reset: all outputs 0; state EMPTY.
- States:
  - EMPTY (rsp_valid=0)
  - FULL (rsp_valid=1)
- Ready rule: req_ready = !flush && (!rsp_valid || rsp_ready). This is combinational; req_ready never depends on req_valid.
- Transitions:
  - EMPTY→FULL on accept.
  - FULL→FULL on accept while rsp_ready (back-to-back, no bubble).
  - FULL→EMPTY on rsp_ready without accept.
  - FULL holds while !rsp_ready; all rsp_* outputs stay stable.
  - flush → EMPTY at next edge, regardless of state or rsp_ready. No accept occurs in a flush cycle.
- Latency: exactly one cycle from accept to rsp_valid.
- Condition (branch kind), evaluated at accept:
  - 000 a==b
  - 001 a!=b
  - 100 signed a<b
  - 101 signed a>=b
  - 110 unsigned a<b
  - 111 unsigned a>=b
  - 010/011: taken=0, illegal=1
- Kind results:
  - branch: taken = condition; target = taken ? pc+imm : pc+4.
  - JAL: taken=1; target = pc+imm.
  - JALR: taken=1; target = (a+imm) with bit0 cleared.
  - reserved kind: taken=0, illegal=1, target = pc+4.
  - All additions are modulo 2^Width; wrap-around is silently allowed.
- rsp_link = pc+4 for every kind.
- Misalignment: rsp_misaligned = taken && target[1] when CompressedEn=0. It is always 0 when CompressedEn=1, because bit0 is already 0 for JALR and the immediates are even.
- Redirect:
  - redirect_valid = 1 only in the single cycle after an accept where taken && !misaligned && !illegal.
  - redirect_pc = target in that cycle, 0 otherwise.
  - Never re-asserted while the result stalls.
  - A flush in the accept cycle is impossible; a flush in the pulse cycle does not cancel the pulse already driven.
- Counters:
  - cnt_branch increments on accept of a branch-kind request with a legal op.
  - cnt_taken increments on the same event when taken.
  - Both saturate at all-ones.
  - cnt_clear takes priority over increment in the same cycle.
- Reset mid-operation: asynchronously drops rsp_valid and redirect_valid, zeroes the counters, and discards the held result.

Test Plan:
- Branch op=100, a=0xFFFFFFFF, b=1, pc=0x100, imm=0x20 -> next cycle rsp_valid=1, taken=1, target=0x120, link=0x104, redirect_valid pulse with redirect_pc=0x120, cnt_branch=1, cnt_taken=1.
- Same operands with op=110 -> taken=0, target=0x104, no redirect pulse, cnt_taken unchanged.
- JALR a=0x1003, imm=0 with CompressedEn=0 -> target=0x1002, misaligned=1, no redirect. Same with CompressedEn=1 -> misaligned=0, redirect to 0x1002.
- rsp_ready held 0 for 3 cycles with req_valid=1 -> req_ready=0, outputs stable, single redirect pulse. Then rsp_ready=1 with a new request -> back-to-back accept, no bubble.
- flush asserted while FULL with req_valid=1 -> req_ready=0, rsp_valid=0 next cycle, counters unchanged. op=011 -> illegal=1, taken=0, cnt_branch unchanged.
- cnt_clear asserted in the same cycle as a taken-branch accept -> counters read 0. Counters preset near max via 2^CntWidth accepts (reduced CntWidth=4) -> saturate at 0xF. Async rst asserted mid-FULL -> all outputs 0 immediately.
